gf180mcu_sram_arbiter: RTL and testbench

Two-port front end for `gf180mcu_sram_wrapper` that shares one single-port SRAM macro between two requesters, such as instruction fetch and data/DMA. It zero-fills the macro after reset, then arbitrates per-cycle requests round-robin. It also converts byte enables into the macro's active-low bit write mask and returns read data with a per-port valid. It sits directly between the bus-side requesters and the wrapper instance.

---
 rtl/gf180mcu_sram_pkg.sv | 24 ++
 rtl/gf180mcu_rr_arb2.sv | 31 +++
 rtl/gf180mcu_sram_arbiter.sv | 121 ++++++++++++
 tb/tb_gf180mcu_sram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_sram_pkg.sv
// Shared types and helpers for the gf180mcu SRAM arbiter front end.
package gf180mcu_sram_pkg;

    // Arbiter controller states: zero-fill sweep, then normal arbitration.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Largest word width the mask helper supports; callers truncate the result.
    localparam int unsigned MAX_WIDTH = 256;
    localparam int unsigned MAX_BE    = MAX_WIDTH / 8;

    // Expand active-high byte enables into the macro's active-low bit write mask.
    function automatic logic [MAX_WIDTH-1:0] be_to_wen(input logic [MAX_BE-1:0] be);
        logic [MAX_WIDTH-1:0] wen;
        wen = '1;
        for (int i = 0; i < int'(MAX_BE); i++) begin
            wen[8*i +: 8] = {8{~be[i]}};
        end
        return wen;
    endfunction

endpackage

// File: rtl/gf180mcu_rr_arb2.sv
// Two-way round-robin arbiter; priority moves away from each accepted port.
module gf180mcu_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] accept,
    output logic [1:0] gnt
);

    logic prio;

    // One-hot grant: a lone requester wins, a tie goes to the priority port.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
    end

    // Priority points at the port that was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (accept[0]) begin
            prio <= 1'b1;
        end else if (accept[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/gf180mcu_sram_arbiter.sv
// Two-port front end sharing one single-port SRAM macro: zero-fill after
// reset, then round-robin arbitration with one access per cycle.
module gf180mcu_sram_arbiter
    import gf180mcu_sram_pkg::*;
#(
    parameter  int unsigned WORDS      = 2048,
    parameter  int unsigned WIDTH      = 64,
    parameter  bit          INIT_ZERO  = 1'b1,
    localparam int unsigned ADDR_WIDTH = $clog2(WORDS),
    localparam int unsigned BE_WIDTH   = WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req,
    output logic [1:0]              gnt,
    input  logic [1:0]              we,
    input  logic [2*BE_WIDTH-1:0]   be,
    input  logic [2*ADDR_WIDTH-1:0] addr,
    input  logic [2*WIDTH-1:0]      wdata,
    output logic [1:0]              rvalid,
    output logic [WIDTH-1:0]        rdata,
    output logic                    init_done,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [WIDTH-1:0]        sram_wen,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [WIDTH-1:0]        sram_din,
    input  logic [WIDTH-1:0]        sram_dout
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  rst_q;
    logic [1:0]            rsp;
    logic                  rsp_rd;
    logic                  run_en;
    logic                  init_en;
    logic [1:0]            arb_req;
    logic [1:0]            gnt_i;
    logic                  sel;
    logic                  we_k;
    logic [BE_WIDTH-1:0]   be_k;
    logic [ADDR_WIDTH-1:0] addr_k;
    logic [WIDTH-1:0]      wdata_k;

    // The cycle right after reset is idle; INIT writes start one cycle later.
    assign run_en  = (state == RUN) && !rst;
    assign init_en = INIT_ZERO && (state == INIT) && !rst && !rst_q;
    assign arb_req = req & {2{run_en}};

    gf180mcu_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .accept (arb_req & gnt_i),
        .gnt    (gnt_i)
    );

    assign gnt     = gnt_i;
    assign sel     = gnt_i[1];
    assign we_k    = we[sel];
    assign be_k    = sel ? be[BE_WIDTH +: BE_WIDTH] : be[0 +: BE_WIDTH];
    assign addr_k  = sel ? addr[ADDR_WIDTH +: ADDR_WIDTH] : addr[0 +: ADDR_WIDTH];
    assign wdata_k = sel ? wdata[WIDTH +: WIDTH] : wdata[0 +: WIDTH];

    // Macro drive: zero-fill write during INIT, granted port during RUN, else idle.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_addr = '0;
        sram_din  = '0;
        if (init_en) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_addr = ADDR_WIDTH'(cnt);
        end else if (|gnt_i) begin
            sram_cen  = 1'b0;
            sram_addr = addr_k;
            if (we_k) begin
                sram_gwen = 1'b0;
                sram_din  = wdata_k;
                sram_wen  = WIDTH'(be_to_wen(MAX_BE'(be_k)));
            end
        end
    end

    // Controller state, init counter and one-cycle response tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            cnt    <= '0;
            rst_q  <= 1'b1;
            rsp    <= 2'b00;
            rsp_rd <= 1'b0;
        end else begin
            rst_q  <= 1'b0;
            rsp    <= gnt_i;
            rsp_rd <= |(gnt_i & ~we);
            if (state == INIT) begin
                if (!INIT_ZERO) begin
                    state <= RUN;
                end else if (init_en) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_WIDTH'(WORDS - 1)) begin
                        state <= RUN;
                    end
                end
            end
        end
    end

    // Responses are dropped the moment reset is asserted.
    assign rvalid    = rsp & {2{!rst}};
    assign rdata     = (rsp_rd && !rst) ? sram_dout : '0;
    assign init_done = (state == RUN) && !rst;

endmodule

// File: tb/tb_gf180mcu_sram_arbiter.sv
// Bench for gf180mcu_sram_arbiter: behavioural macro, cycle model and directed tests.
module tb_gf180mcu_sram_arbiter;

    localparam int WORDS = 2048;
    localparam int AW    = 11;
    localparam logic [63:0] D1  = 64'h6D6C_6B6A_6968_6766;
    localparam logic [63:0] X11 = 64'hFFFF_FFFF_89AB_CDEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   = 1'b1;
    logic [1:0]    req   = 2'b00;
    logic [1:0]    we    = 2'b00;
    logic [15:0]   be    = '0;
    logic [21:0]   addr  = '0;
    logic [127:0]  wdata = '0;
    logic [1:0]    gnt, rvalid;
    logic [63:0]   rdata, sram_wen, sram_din;
    logic [63:0]   sram_dout = '0;
    logic          init_done, sram_cen, sram_gwen;
    logic [AW-1:0] sram_addr;

    logic [1:0]    req_b = 2'b01;
    logic [1:0]    we_b  = 2'b00;
    logic [15:0]   be_b  = '0;
    logic [7:0]    addr_b = '0;
    logic [127:0]  wdata_b = '0;
    logic [63:0]   dout_b = '0;
    logic [1:0]    gnt_b, rvalid_b;
    logic [63:0]   rdata_b, wen_b, din_b;
    logic          init_done_b, cen_b, gwen_b;
    logic [3:0]    saddr_b;

    int n_tests = 0;
    int n_fail  = 0;

    gf180mcu_sram_arbiter #(.WORDS(2048), .WIDTH(64), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .we(we), .be(be),
        .addr(addr), .wdata(wdata), .rvalid(rvalid), .rdata(rdata),
        .init_done(init_done), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    gf180mcu_sram_arbiter #(.WORDS(16), .WIDTH(64), .INIT_ZERO(1'b0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .we(we_b), .be(be_b),
        .addr(addr_b), .wdata(wdata_b), .rvalid(rvalid_b), .rdata(rdata_b),
        .init_done(init_done_b), .sram_cen(cen_b), .sram_gwen(gwen_b),
        .sram_wen(wen_b), .sram_addr(saddr_b), .sram_din(din_b),
        .sram_dout(dout_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Power-up contents of a never-written word.
    function automatic logic [63:0] garb(input logic [AW-1:0] a);
        return {32'hDEAD_BEEF, 21'h0, a};
    endfunction

    // Behavioural single-port macro: bit-masked write, registered read.
    logic [63:0] mem [WORDS];
    bit          mem_wr [WORDS];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                mem[sram_addr]    <= ((mem_wr[sram_addr] ? mem[sram_addr] : garb(sram_addr)) & sram_wen)
                                     | (sram_din & ~sram_wen);
                mem_wr[sram_addr] <= 1'b1;
            end else begin
                sram_dout <= mem_wr[sram_addr] ? mem[sram_addr] : garb(sram_addr);
            end
        end
    end

    // Cycle model: expected outputs from reset age, request pattern and shadow array.
    logic [63:0] shadow [WORDS];
    bit          sh_wr [WORDS];
    int          m_since = 0;
    logic        m_prio = 1'b0;
    logic [1:0]  m_pend = 2'b00;
    logic        m_pend_rd = 1'b0;
    logic [63:0] m_pend_data = '0;

    always @(negedge clk) begin : cmp
        logic [1:0]    eg, erv;
        logic          ecen, egwen, eidone;
        logic [63:0]   ewen, edin, erd, cur;
        logic [AW-1:0] eaddr;
        int            p;
        eg = 2'b00; ecen = 1'b1; egwen = 1'b1; ewen = '1; edin = '0; eaddr = '0;
        eidone = 1'b0; p = 0;
        erv = rst ? 2'b00 : m_pend;
        erd = (!rst && m_pend_rd) ? m_pend_data : 64'h0;
        if (!rst && m_since >= 1 && m_since <= WORDS) begin
            ecen = 1'b0; egwen = 1'b0; ewen = '0; eaddr = AW'(m_since - 1);
        end else if (!rst && m_since > WORDS) begin
            eidone = 1'b1;
            if (req == 2'b11) eg = m_prio ? 2'b10 : 2'b01;
            else eg = req;
            if (eg != 2'b00) begin
                p = eg[1] ? 1 : 0;
                ecen = 1'b0;
                eaddr = addr[p*AW +: AW];
                if (we[p]) begin
                    egwen = 1'b0;
                    edin = wdata[p*64 +: 64];
                    for (int i = 0; i < 8; i++) ewen[8*i +: 8] = be[p*8+i] ? 8'h00 : 8'hFF;
                end
            end
        end
        chk("m_gnt", 64'(gnt), 64'(eg));
        chk("m_rvalid", 64'(rvalid), 64'(erv));
        chk("m_rdata", rdata, erd);
        chk("m_init_done", 64'(init_done), 64'(eidone));
        chk("m_cen", 64'(sram_cen), 64'(ecen));
        chk("m_gwen", 64'(sram_gwen), 64'(egwen));
        chk("m_wen", sram_wen, ewen);
        chk("m_addr", 64'(sram_addr), 64'(eaddr));
        chk("m_din", sram_din, edin);
        if (rst) begin
            m_since = 0; m_prio = 1'b0; m_pend = 2'b00; m_pend_rd = 1'b0;
        end else begin
            m_since++;
            cur = sh_wr[eaddr] ? shadow[eaddr] : garb(eaddr);
            m_pend = eg;
            m_pend_rd = (eg != 2'b00) && !we[p];
            m_pend_data = cur;
            if (!ecen && !egwen) begin
                for (int i = 0; i < 8; i++) if (ewen[8*i] == 1'b0) cur[8*i +: 8] = edin[8*i +: 8];
                shadow[eaddr] = cur;
                sh_wr[eaddr] = 1'b1;
            end
            if (eg[0]) m_prio = 1'b1;
            else if (eg[1]) m_prio = 1'b0;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Release reset and follow the zero-fill sweep until init_done.
    task automatic release_and_init();
        int  n;
        logic done;
        rst = 1'b0;
        @(negedge clk);
        chk("k0_cen", 64'(sram_cen), 64'(1'b1));
        chk("k0_rvalid", 64'(rvalid), 64'(2'b00));
        nxt();
        @(negedge clk);
        chk("init_first_addr", 64'(sram_addr), 64'h0);
        chk("init_first_cen", 64'(sram_cen), 64'(1'b0));
        nxt();
        n = 0;
        do begin
            @(negedge clk);
            done = init_done;
            nxt();
            n++;
        end while (!done && n < 4000);
        chk("init_len", 64'(n), 64'(WORDS));
    endtask

    // Issue one access on port p, hold until granted, return the response data.
    task automatic xfer(input int p, input logic w, input logic [7:0] b,
                        input logic [AW-1:0] a, input logic [63:0] d, output logic [63:0] rd);
        int   n;
        logic g;
        req[p] = 1'b1; we[p] = w; be[p*8 +: 8] = b; addr[p*AW +: AW] = a; wdata[p*64 +: 64] = d;
        n = 0;
        do begin
            @(negedge clk);
            g = gnt[p];
            nxt();
            n++;
        end while (!g && n < 20);
        chk("gnt_wait", 64'(g), 64'(1'b1));
        req[p] = 1'b0;
        @(negedge clk);
        chk("rvalid_resp", 64'(rvalid[p]), 64'(1'b1));
        rd = rdata;
        nxt();
    endtask

    initial begin
        logic [63:0] r;
        logic        g;
        int          n;
        #1;
        repeat (2) nxt();
        @(negedge clk);
        chk("rst_cen", 64'(sram_cen), 64'(1'b1));
        chk("rst_init_done", 64'(init_done), 64'(1'b0));
        chk("b_rst_gnt", 64'(gnt_b), 64'(2'b00));
        chk("b_rst_cen", 64'(cen_b), 64'(1'b1));
        nxt();
        // Second instance: RUN and a grant on the second cycle after reset.
        rst = 1'b0;
        @(negedge clk);
        chk("b_k0_done", 64'(init_done_b), 64'(1'b0));
        chk("b_k0_gnt", 64'(gnt_b), 64'(2'b00));
        chk("k0_cen", 64'(sram_cen), 64'(1'b1));
        nxt();
        @(negedge clk);
        chk("b_k1_done", 64'(init_done_b), 64'(1'b1));
        chk("b_k1_gnt", 64'(gnt_b), 64'(2'b01));
        chk("b_k1_cen", 64'(cen_b), 64'(1'b0));
        chk("init_first_addr", 64'(sram_addr), 64'h0);
        nxt();
        req_b = 2'b00;
        n = 0;
        do begin
            @(negedge clk);
            g = init_done;
            nxt();
            n++;
        end while (!g && n < 4000);
        chk("init_len", 64'(n), 64'(WORDS));

        xfer(0, 1'b0, 8'h00, 11'h7FF, 64'h0, r);  chk("rd_7ff", r, 64'h0);
        xfer(0, 1'b1, 8'hFF, 11'h010, D1, r);     chk("wr_rdata_zero", r, 64'h0);
        xfer(0, 1'b0, 8'h00, 11'h010, 64'h0, r);  chk("rd_10", r, D1);
        xfer(0, 1'b1, 8'hFF, 11'h011, '1, r);
        xfer(0, 1'b1, 8'h0F, 11'h011, 64'h0123_4567_89AB_CDEF, r);
        xfer(0, 1'b0, 8'h00, 11'h011, 64'h0, r);  chk("rd_11_mask", r, X11);
        xfer(1, 1'b1, 8'h00, 11'h010, 64'hAAAA_5555_AAAA_5555, r);
        xfer(0, 1'b0, 8'h00, 11'h010, 64'h0, r);  chk("be0_unchanged", r, D1);
        xfer(1, 1'b0, 8'h00, 11'h011, 64'h0, r);  chk("p1_rd_11", r, X11);

        // Contention: both ports read continuously.
        we = 2'b00; addr[0 +: AW] = 11'h010; addr[AW +: AW] = 11'h011; req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("cont_gnt", 64'(gnt), (i % 2 == 1) ? 64'h2 : 64'h1);
            if (i > 0) begin
                chk("cont_rvalid", 64'(rvalid), (i % 2 == 1) ? 64'h1 : 64'h2);
                chk("cont_rdata", rdata, (i % 2 == 1) ? D1 : X11);
            end
            nxt();
        end
        req = 2'b00;
        @(negedge clk);
        chk("cont_last_rvalid", 64'(rvalid), 64'h2);
        chk("cont_last_rdata", rdata, X11);
        nxt();

        // Reset the cycle after a port 1 read grant.
        we[1] = 1'b0; addr[AW +: AW] = 11'h010; req[1] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            g = gnt[1];
            nxt();
            n++;
        end while (!g && n < 20);
        chk("rst_gnt_wait", 64'(g), 64'(1'b1));
        rst = 1'b1; req = 2'b00;
        @(negedge clk);
        chk("rst_drop_rvalid", 64'(rvalid), 64'h0);
        chk("rst_drop_rdata", rdata, 64'h0);
        chk("rst_drop_done", 64'(init_done), 64'h0);
        nxt();
        release_and_init();
        xfer(0, 1'b0, 8'h00, 11'h010, 64'h0, r);  chk("reinit_rd_10", r, 64'h0);

        // Idle bus.
        req = 2'b00;
        repeat (5) begin
            @(negedge clk);
            chk("idle_cen", 64'(sram_cen), 64'(1'b1));
            chk("idle_wen", sram_wen, '1);
            nxt();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
